serial_addsub: RTL and testbench

SERIAL_ADDSUB -- requirements
Module: serial_addsub

---
 rtl/serial_addsub_pkg.sv | 13 +
 rtl/serial_addsub_full_adder.sv | 13 +
 rtl/serial_addsub.sv | 102 ++++++++++
 tb/tb_serial_addsub.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/serial_addsub_pkg.sv
// Shared types and defaults for the bit-serial adder/subtractor.
// Holds the controller state encoding and the default operand width.
package serial_addsub_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_addsub_full_adder.sv
// One-bit full adder cell used as the serial datapath of serial_addsub.
module full_adder (
  input  logic A,
  input  logic B,
  input  logic C,
  output logic sum,
  output logic cout
);

  assign sum  = A ^ B ^ C;
  assign cout = (A & B) | (C & (A ^ B));

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial add/subtract: one full adder processes LSB-first, one bit per cycle.
//
//   state | meaning
//   IDLE  | waiting for start; last result held on sum/cout/ovf
//   RUN   | one bit pair added per cycle, WIDTH cycles total
//   DONE  | one-cycle result-valid pulse; start here chains the next operation
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_sum;
  logic             r_c;
  logic             r_cout;
  logic             r_ovf;
  logic [CW-1:0]    r_cnt;
  logic             w_s;
  logic             w_co;
  logic             w_last;

  full_adder u_fa (
    .A   (r_a[0]),
    .B   (r_b[0]),
    .C   (r_c),
    .sum (w_s),
    .cout(w_co)
  );

  assign w_last = (r_cnt == LAST);

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = RUN;
      RUN:     if (w_last) w_next = DONE;
      DONE:    w_next = start ? RUN : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_sum   <= '0;
      r_c     <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == RUN) begin
        r_a   <= r_a >> 1;
        r_b   <= r_b >> 1;
        r_res <= {w_s, r_res[WIDTH-1:1]};
        r_c   <= w_co;
        r_cnt <= r_cnt + 1'b1;
        // On the final bit r_c still holds the carry into the MSB.
        if (w_last) begin
          r_sum  <= {w_s, r_res[WIDTH-1:1]};
          r_cout <= w_co;
          r_ovf  <= r_c ^ w_co;
        end
      end else if (start) begin
        r_a   <= A;
        r_b   <= B ^ {WIDTH{sub}};
        r_c   <= sub;
        r_cnt <= '0;
      end
    end
  end

  assign busy = (r_state == RUN);
  assign done = (r_state == DONE);
  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_serial_addsub.sv
// Directed bench for serial_addsub (WIDTH=8) with a result scoreboard queue.
module tb_serial_addsub;
  import serial_addsub_pkg::*;

  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } res_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  res_t exp_q[$];
  int   n_asserts = 0;
  int   n_fail = 0;
  int   n_done = 0;
  int   cyc = 0;

  serial_addsub #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .sub  (sub),
    .A    (A),
    .B    (B),
    .busy (busy),
    .done (done),
    .sum  (sum),
    .cout (cout),
    .ovf  (ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    res_t r;
    logic [W:0] full;
    if (s) begin
      r.sum  = a - b;
      r.cout = (a >= b);
      r.ovf  = (a[W-1] != b[W-1]) && (r.sum[W-1] != a[W-1]);
    end else begin
      full   = {1'b0, a} + {1'b0, b};
      r.sum  = full[W-1:0];
      r.cout = full[W];
      r.ovf  = (a[W-1] == b[W-1]) && (r.sum[W-1] != a[W-1]);
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest pending expectation.
  always @(negedge clk) begin : monitor
    res_t e;
    if (done === 1'b1) begin
      n_done++;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("sum", 32'(sum), 32'(e.sum));
        check("cout", 32'(cout), 32'(e.cout));
        check("ovf", 32'(ovf), 32'(e.ovf));
      end
    end
  end

  // Launch one op; poke_k>0 re-pulses start with junk operands on that RUN cycle.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input int poke_k);
    res_t e;
    int   edges;
    int   bc;
    e = model(a, b, s);
    @(negedge clk);
    A = a; B = b; sub = s; start = 1'b1;
    exp_q.push_back(e);
    edges = 0;
    bc = 0;
    do begin
      @(negedge clk);
      edges++;
      if (edges == 1) start = 1'b0;
      if (poke_k > 0 && edges == poke_k) begin
        A = ~a; B = a ^ b; sub = ~s; start = 1'b1;
      end
      if (poke_k > 0 && edges == poke_k + 1) start = 1'b0;
      if (busy === 1'b1) bc++;
    end while (done !== 1'b1 && edges < 40);
    check("latency", edges, 32'd9);
    check("busy_cycles", bc, 32'd8);
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
    check("idle_after_done", 32'(busy), 32'd0);
    check("sum_hold", 32'(sum), 32'(e.sum));
  endtask

  initial begin : main
    int   k;
    int   c1;
    int   nd;
    res_t e2;

    repeat (3) @(negedge clk);
    check("reset_outputs", {27'd0, busy, done, cout, ovf, 1'b0} | 32'(sum), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_outputs", {27'd0, busy, done, cout, ovf, 1'b0} | 32'(sum), 32'd0);

    run_op(8'h35, 8'h4A, 1'b0, 0);
    run_op(8'h7F, 8'h01, 1'b0, 0);
    run_op(8'hFF, 8'h01, 1'b0, 0);
    run_op(8'h05, 8'h07, 1'b1, 0);
    run_op(8'h80, 8'h01, 1'b1, 0);
    run_op(8'h00, 8'h00, 1'b1, 0);
    run_op(8'h9C, 8'h9C, 1'b1, 0);
    for (int i = 0; i < 4; i++)
      run_op(8'($urandom), 8'($urandom), 1'($urandom), 0);

    // start re-pulsed on the 3rd RUN cycle must be ignored
    nd = n_done;
    run_op(8'h12, 8'h34, 1'b0, 3);
    repeat (15) @(negedge clk);
    check("single_done_after_poke", n_done - nd, 32'd1);

    // back-to-back: start held high across DONE
    @(negedge clk);
    A = 8'h35; B = 8'h4A; sub = 1'b0; start = 1'b1;
    exp_q.push_back(model(8'h35, 8'h4A, 1'b0));
    k = 0;
    do begin @(negedge clk); k++; end while (done !== 1'b1 && k < 40);
    check("b2b_first_done", 32'(done), 32'd1);
    c1 = cyc;
    A = 8'h80; B = 8'h01; sub = 1'b1;
    e2 = model(8'h80, 8'h01, 1'b1);
    exp_q.push_back(e2);
    @(negedge clk);
    start = 1'b0;
    check("b2b_no_idle", 32'(busy), 32'd1);
    k = 0;
    do begin @(negedge clk); k++; end while (done !== 1'b1 && k < 40);
    check("b2b_second_done", 32'(done), 32'd1);
    check("b2b_spacing", cyc - c1, 32'd9);

    // reset on the 4th RUN cycle aborts the op
    @(negedge clk);
    A = 8'h55; B = 8'h22; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_outputs", {27'd0, busy, done, cout, ovf, 1'b0} | 32'(sum), 32'd0);
    nd = n_done;
    repeat (15) @(negedge clk);
    check("abort_no_done", n_done - nd, 32'd0);
    run_op(8'hC3, 8'h3C, 1'b0, 0);

    check("queue_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
